// File: rtl/t_frame_scheduler.sv
// Purpose: round-robin transmit frame scheduler, 4 requesters -> one serial 16-bit {HEADER, payload} channel.
// Latency: grant is combinational in the boundary cycle T; frame bit 15 on data_out at T+1, bit 0 at T+16.
// Backpressure: none on the wire side; requesters hold req/payload until granted, en only acts at frame boundaries.
module t_frame_scheduler #(
    parameter logic [3:0]  HEADER       = 4'd6,
    parameter logic [11:0] IDLE_PAYLOAD = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [3:0]  i_req,
    input  logic [47:0] i_payload,
    output logic [3:0]  o_grant,
    output logic        o_data_out,
    output logic        o_frame_start,
    output logic [1:0]  o_cur_id,
    output logic        o_cur_valid
);

    logic [15:0] r_shift;
    logic [3:0]  r_cnt;
    logic [1:0]  r_ptr;
    logic        r_run;
    logic        r_frame_start;
    logic [1:0]  r_cur_id;
    logic        r_cur_valid;

    logic        w_boundary;
    logic        w_win_vld;
    logic [1:0]  w_win_idx;
    logic        w_grant_fire;
    logic [11:0] w_payload_sel;

    assign w_boundary = (r_cnt == 4'd15);

    // Round-robin search: ptr+1 has highest priority, ptr itself lowest.
    // Scanning from the lowest-priority offset upward lets the best match overwrite.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = r_ptr;
        for (int o = 4; o >= 1; o--) begin
            if (i_req[r_ptr + 2'(o)]) begin
                w_win_vld = 1'b1;
                w_win_idx = r_ptr + 2'(o);
            end
        end
    end

    // Grant is only visible in a running boundary cycle and never while reset is held.
    assign w_grant_fire  = w_boundary && i_en && w_win_vld && !i_rst;
    assign w_payload_sel = i_payload[w_win_idx * 12 +: 12];
    assign o_grant       = w_grant_fire ? (4'b0001 << w_win_idx) : 4'b0000;

    // Bit counter: free-running, the value 15 marks the frame boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 4'd15;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Shift register: load a new frame at the boundary, otherwise shift out MSB first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= 16'h0000;
        end else if (w_boundary) begin
            if (!i_en) begin
                r_shift <= 16'h0000;
            end else if (w_win_vld) begin
                r_shift <= {HEADER, w_payload_sel};
            end else begin
                r_shift <= {HEADER, IDLE_PAYLOAD};
            end
        end else begin
            r_shift <= {r_shift[14:0], 1'b0};
        end
    end

    // Frame ownership, run flag and frame_start, all updated on the boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr         <= 2'd3;
            r_run         <= 1'b0;
            r_frame_start <= 1'b0;
            r_cur_id      <= 2'd0;
            r_cur_valid   <= 1'b0;
        end else if (w_boundary) begin
            r_run         <= i_en;
            r_frame_start <= i_en;
            if (i_en && w_win_vld) begin
                r_ptr       <= w_win_idx;
                r_cur_id    <= w_win_idx;
                r_cur_valid <= 1'b1;
            end else begin
                r_cur_valid <= 1'b0;
            end
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign o_data_out    = r_shift[15];
    assign o_frame_start = r_frame_start;
    assign o_cur_id      = r_cur_id;
    assign o_cur_valid   = r_cur_valid;

endmodule

// File: doc/t_frame_scheduler.md
Name: t_frame_scheduler

Overview:
- Transmit-side frame scheduler; counterpart of the receive framer.
- Shares one serial 16-bit frame channel between 4 payload requesters using round-robin arbitration.
- Builds each frame as {HEADER[3:0], payload[11:0]} and shifts it out MSB first, back to back.
- Sends idle frames when no requester is pending, so the far-end framer keeps header lock.

Parameters:
- HEADER, 6, 4-bit frame header placed in frame bits [15:12].
- IDLE_PAYLOAD, 12'h000, payload used in idle frames.

Ports:
- clk  in  1  system clock; one serial bit per cycle.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  transmit enable; sampled only at frame boundaries.
- req  in  4  req[i] high = requester i has a payload pending.
- payload  in  48  payload of requester i on bits [12i+11:12i]; must be held stable while req[i] is high.
- grant  out  4  one-hot, single-cycle pulse; requester i's payload is captured in that cycle.
- data_out  out  1  serial frame bit; equals shift-register bit 15.
- frame_start  out  1  high in the cycle data_out carries frame bit 15.
- cur_id  out  2  index of the requester that owns the frame on the wire.
- cur_valid  out  1  1 = frame on wire carries requester data; 0 = idle frame or stopped.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - shift register = 0, so data_out = 0.
  - bit counter cnt[3:0] = 15.
  - round-robin pointer ptr = 3, so requester 0 has first priority.
  - grant = 0, frame_start = 0, cur_id = 0, cur_valid = 0, run flag = 0.
- Bit counter: increments every cycle and wraps 15 -> 0. The cycle with cnt == 15 is the boundary cycle.
- Outside the boundary cycle: shift register shifts left by 1 with 0 fill. grant = 0.
- Boundary cycle actions:
  - run <= en.
  - If en = 1 and req != 0: grant the first set req in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
    - Assert grant[k] for that cycle only.
    - Shift register <= {HEADER, payload_k}; ptr <= k; cur_id <= k; cur_valid <= 1.
  - If en = 1 and req == 0: shift register <= {HEADER, IDLE_PAYLOAD}; cur_valid <= 0; ptr and cur_id unchanged; no grant.
  - If en = 0: shift register <= 0; cur_valid <= 0; no grant.
- Latency:
  - Grant cycle is T. Frame bit 15 appears on data_out at T+1; bit 0 appears at T+16. The next boundary is at T+16.
  - frame_start is registered and equals (cnt == 0) && run.
- First frame after reset: the boundary occurs in the first clock after rst falls, so frame bit 15 appears on the second clock.
- en behaviour:
  - en is ignored mid-frame; a frame in progress always completes all 16 bits.
  - While stopped, data_out = 0 and frame_start = 0. The far-end framer loses lock.
- Simultaneous events:
  - req rising in the boundary cycle is eligible that cycle.
  - req dropping in the grant cycle has no effect; the grant still stands.
  - A requester holding req high wins at most once per 4 frames when all 4 are requesting.
- Arithmetic: ptr and index arithmetic are modulo 4. cnt wraps with no overflow flag.
- Reset mid-frame: the frame is truncated immediately, data_out = 0, and sequencing restarts as after power-up.

Test Plan:
1. Reset, en=1, req=4'b0001, payload0=12'hABC. Expect:
   - grant=4'b0001 on the first clock after rst falls.
   - Next 16 data_out bits: 0110 1010 1011 1100.
   - frame_start on the first bit; cur_id=0, cur_valid=1.
2. en=1, req=4'b1111 held, payload i = 12'h100*(i+1). Expect:
   - grants in order 0,1,2,3,0, one every 16 cycles.
   - Frame payloads 100, 200, 300, 400, 100.
3. en=1, req=0 for 3 frames. Expect:
   - frames 0110 0000 0000 0000, repeated every 16 cycles.
   - grant never asserted; cur_valid=0; frame_start every 16 cycles.
4. Requester 2 granted (ptr=2), then req=4'b0101 at the next boundary. Expect grant=4'b0001 (search order 3,0,1,2).
5. en drops at bit 5 of a data frame. Expect:
   - that frame completes all 16 bits.
   - then data_out=0, no frame_start, no grant until en=1 at a boundary.
   - resumed frame starts the cycle after that boundary.
6. rst pulsed at bit 8 of a frame, req=4'b0100. Expect:
   - data_out=0 immediately.
   - grant=4'b0100 on the first clock after release.
   - a full frame follows with payload2.
